// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-facing VRAM port.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_REQ   = 3'd2,
    ST_CAP   = 3'd3,
    ST_PREQ  = 3'd4,
    ST_PCAP  = 3'd5
  } state_t;

  localparam logic [2:0] REG_PPUCTRL   = 3'd0;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_PPUADDR   = 3'd6;
  localparam logic [2:0] REG_PPUDATA   = 3'd7;

  localparam logic [13:0] PALETTE_BASE  = 14'h3F00;
  localparam logic [13:0] NT_MIRROR_OFS = 14'h1000;

  // Step applied to v after every PPUDATA access.
  function automatic logic [13:0] vram_inc(input logic inc32);
    return inc32 ? 14'd32 : 14'd1;
  endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// PPUADDR two-write latch and PPUDATA access sequencer with delayed read buffer.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter bit PAL_BUFFER_FILL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  state_t      r_state;
  logic [13:0] r_v;
  logic [5:0]  r_t_hi;
  logic        r_w;
  logic        r_inc32;
  logic [7:0]  r_read_buf;
  logic [7:0]  r_cpu_data_out;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_mem_wdata_vld_unused;
  logic [7:0]  r_mem_wdata;
  logic        r_busy;

  logic [13:0] w_v_next;
  logic        w_is_pal;

  assign w_v_next = r_v + vram_inc(r_inc32);
  assign w_is_pal = (r_v >= PALETTE_BASE);

  assign cpu_data_out = r_cpu_data_out;
  assign busy         = r_busy;
  assign mem_addr     = r_mem_addr;
  assign mem_rd       = r_mem_rd;
  assign mem_wr       = r_mem_wr;
  assign mem_wdata    = r_mem_wdata;

  // Register decode plus access sequencing; mem_addr tracks v except during
  // the palette refill, where it points at the underlying nametable byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state                <= ST_IDLE;
      r_v                    <= '0;
      r_t_hi                 <= '0;
      r_w                    <= 1'b0;
      r_inc32                <= 1'b0;
      r_read_buf             <= '0;
      r_cpu_data_out         <= '0;
      r_mem_addr             <= '0;
      r_mem_rd               <= 1'b0;
      r_mem_wr               <= 1'b0;
      r_mem_wdata            <= '0;
      r_busy                 <= 1'b0;
      r_mem_wdata_vld_unused <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_wr) begin
            case (cpu_addr)
              REG_PPUCTRL: r_inc32 <= cpu_data_in[2];
              REG_PPUADDR: begin
                if (!r_w) begin
                  r_t_hi <= cpu_data_in[5:0];
                  r_w    <= 1'b1;
                end else begin
                  r_v        <= {r_t_hi, cpu_data_in};
                  r_mem_addr <= {2'b00, r_t_hi, cpu_data_in};
                  r_w        <= 1'b0;
                end
              end
              REG_PPUDATA: begin
                r_state     <= ST_WRITE;
                r_busy      <= 1'b1;
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= cpu_data_in;
              end
              default: ;
            endcase
          end else if (cpu_rd) begin
            case (cpu_addr)
              REG_PPUSTATUS: r_w <= 1'b0;
              REG_PPUDATA: begin
                if (!w_is_pal) r_cpu_data_out <= r_read_buf;
                r_state  <= ST_REQ;
                r_busy   <= 1'b1;
                r_mem_rd <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          r_v        <= w_v_next;
          r_mem_addr <= {2'b00, w_v_next};
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
        end
        ST_REQ: begin
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          if (w_is_pal) begin
            r_cpu_data_out <= mem_rdata;
            if (PAL_BUFFER_FILL) begin
              r_state    <= ST_PREQ;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {2'b00, r_v - NT_MIRROR_OFS};
            end else begin
              r_v        <= w_v_next;
              r_mem_addr <= {2'b00, w_v_next};
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
            end
          end else begin
            r_read_buf <= mem_rdata;
            r_v        <= w_v_next;
            r_mem_addr <= {2'b00, w_v_next};
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
          end
        end
        ST_PREQ: begin
          r_state <= ST_PCAP;
        end
        ST_PCAP: begin
          r_read_buf <= mem_rdata;
          r_v        <= w_v_next;
          r_mem_addr <= {2'b00, w_v_next};
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed scoreboard bench for ppu_vram_port.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cpu_addr = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_data_in = '0;
  logic [7:0]  cpu_data_out;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic [7:0]  mem [0:16383];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  ppu_vram_port #(.PAL_BUFFER_FILL(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // VRAM model: one-cycle read latency, writes on the strobe edge.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[13:0]];
    if (mem_wr) mem[mem_addr[13:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // Present strobes for one sampling edge; returns just after that edge.
  task automatic strobe(input logic wr, input logic rd, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_data_in = d;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    int n;
    push("reg_busy", 16'd0);
    strobe(1'b1, 1'b0, a, d);
    wait_idle(n);
    pop_chk(16'(n));
  endtask

  task automatic set_v(input logic [13:0] v);
    reg_write(3'd6, {2'b00, v[13:8]});
    reg_write(3'd6, v[7:0]);
  endtask

  task automatic chk_v(input logic [13:0] v);
    chk("v", mem_addr, {2'b00, v});
  endtask

  task automatic data_write(input logic [13:0] a, input logic [7:0] d);
    int n;
    push("wr_addr", {2'b00, a});
    push("wr_data", {8'h00, d});
    push("wr_busy", 16'd1);
    strobe(1'b1, 1'b0, 3'd7, d);
    chk("mem_wr", {15'd0, mem_wr}, 16'd1);
    pop_chk(mem_addr);
    pop_chk({8'h00, mem_wdata});
    wait_idle(n);
    pop_chk(16'(n));
    chk("mem_wr_one_cycle", {15'd0, mem_wr}, 16'd0);
  endtask

  task automatic data_read(input logic [7:0] d, input int nbusy);
    int n;
    push("rd_busy", 16'(nbusy));
    push("rd_data", {8'h00, d});
    strobe(1'b0, 1'b1, 3'd7, 8'h00);
    chk("mem_rd", {15'd0, mem_rd}, 16'd1);
    wait_idle(n);
    pop_chk(16'(n));
    pop_chk({8'h00, cpu_data_out});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_data_out", {8'h00, cpu_data_out}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_ctl", {14'd0, mem_rd, mem_wr}, 16'd0);
    chk("rst_wdata", {8'h00, mem_wdata}, 16'h0000);

    // Address latch and write with auto-increment.
    reg_write(3'd6, 8'h21);
    reg_write(3'd6, 8'h08);
    data_write(14'h2108, 8'h55);
    chk_v(14'h2109);

    // Preload memory through the port itself.
    set_v(14'h2000);
    data_write(14'h2000, 8'hAA);
    data_write(14'h2001, 8'hBB);
    set_v(14'h3F00);
    data_write(14'h3F00, 8'h0F);
    set_v(14'h2F00);
    data_write(14'h2F00, 8'h33);

    // Delayed read buffer.
    do_reset();
    chk_v(14'h0000);
    set_v(14'h2000);
    data_read(8'h00, 2);
    data_read(8'hAA, 2);
    data_read(8'hBB, 2);
    chk_v(14'h2003);

    // Palette read refills buffer from the nametable byte underneath.
    set_v(14'h3F00);
    data_read(8'h0F, 4);
    chk_v(14'h3F01);
    set_v(14'h2000);
    data_read(8'h33, 2);

    // Increment by 32 and wrap; increment by 1 and wrap.
    reg_write(3'd0, 8'h04);
    set_v(14'h3FE0);
    data_write(14'h3FE0, 8'h11);
    chk_v(14'h0000);
    reg_write(3'd0, 8'h00);
    set_v(14'h3FFF);
    data_write(14'h3FFF, 8'h22);
    chk_v(14'h0000);

    // Status read clears the write toggle.
    reg_write(3'd6, 8'h3F);
    push("status_busy", 16'd0);
    strobe(1'b0, 1'b1, 3'd2, 8'h00);
    wait_idle(n);
    pop_chk(16'(n));
    reg_write(3'd6, 8'h23);
    reg_write(3'd6, 8'h00);
    chk_v(14'h2300);

    // PPUADDR write presented while busy is dropped and leaves w alone.
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 3'd7;
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 3'd6; cpu_data_in = 8'h12;
    chk("busy_req", {15'd0, busy}, 16'd1);
    chk("req_addr", mem_addr, 16'h2300);
    @(negedge clk);
    cpu_wr = 1'b0;
    wait_idle(n);
    chk("busy_drop_rdata", {8'h00, cpu_data_out}, 16'h00AA);
    chk_v(14'h2301);
    set_v(14'h2500);
    chk_v(14'h2500);

    // Simultaneous write and read strobes: write wins.
    strobe(1'b1, 1'b1, 3'd7, 8'h77);
    chk("coll_wr", {15'd0, mem_wr}, 16'd1);
    chk("coll_rd", {15'd0, mem_rd}, 16'd0);
    chk("coll_addr", mem_addr, 16'h2500);
    chk("coll_wdata", {8'h00, mem_wdata}, 16'h0077);
    wait_idle(n);
    chk("coll_busy", 16'(n), 16'd1);
    chk_v(14'h2501);

    // Asynchronous reset during REQ.
    set_v(14'h2600);
    strobe(1'b0, 1'b1, 3'd7, 8'h00);
    chk("pre_rst_rd", {15'd0, mem_rd}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd", {15'd0, mem_rd}, 16'd0);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_v(14'h0000);
    chk("post_rst_rd", {15'd0, mem_rd}, 16'd0);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ppu_vram_port.md
# ppu_vram_port

CPU-facing VRAM access port of the PPU: implements the PPUADDR ($2006) two-write address latch and PPUDATA ($2007) read/write with auto-increment and the delayed read buffer. It originates every raw 16-bit PPU address for CPU-initiated VRAM traffic. Its `mem_addr` drives `ppu_mem_decode` in the parent, which performs mirroring before the physical RAM.

## Interface
Parameters:
- `PAL_BUFFER_FILL`, default 1. When 1, a palette read also refills the read buffer from the underlying nametable byte at v-0x1000.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_addr`  in  3  register select, CPU address bits [2:0].
- `cpu_wr`  in  1  CPU write strobe, one cycle.
- `cpu_rd`  in  1  CPU read strobe, one cycle.
- `cpu_data_in`  in  8  CPU write data.
- `cpu_data_out`  out  8  registered PPUDATA read result.
- `busy`  out  1  access in progress; CPU strobes are ignored while high.
- `mem_addr`  out  16  raw PPU address, equal to {2'b00, v}.
- `mem_rd`  out  1  VRAM read request.
- `mem_wr`  out  1  VRAM write strobe.
- `mem_wdata`  out  8  VRAM write data.
- `mem_rdata`  in  8  VRAM read data, valid the cycle after `mem_rd`.

## Operation
Internal registers:
- `v`: 14-bit current address.
- `t_hi`: 6-bit latched high byte.
- `w`: 1-bit write toggle.
- `inc32`: 1-bit increment-mode flag.
- `read_buf`: 8-bit read buffer.

Register-select behaviour (other `cpu_addr` values are ignored):
- **$2000 write:** `inc32` <= `cpu_data_in[2]`.
- **$2002 read:** `w` <= 0. This block does not drive the status data.
- **$2006 write, w=0:** `t_hi` <= `cpu_data_in[5:0]`; `w` <= 1.
- **$2006 write, w=1:** `v` <= {`t_hi`, `cpu_data_in`}; `w` <= 0.
- **$2007 write:** state goes to WRITE. `mem_addr`=v, `mem_wdata`=`cpu_data_in`, `mem_wr`=1 for exactly one cycle. Then v += inc, return to IDLE.
- **$2007 read, v < 0x3F00:** `cpu_data_out` <= `read_buf` on the sampling edge. Then REQ (`mem_rd`=1, `mem_addr`=v), then CAP (`read_buf` <= `mem_rdata`, v += inc), then IDLE.
- **$2007 read, v >= 0x3F00 (palette):** REQ, then CAP (`cpu_data_out` <= `mem_rdata`). If `PAL_BUFFER_FILL`: PREQ (`mem_rd`=1, `mem_addr`={2'b00, v-14'h1000}), then PCAP (`read_buf` <= `mem_rdata`). Then v += inc and return to IDLE.

Rules that apply in every state:
- Increment (inc) is 32 when `inc32`=1, else 1.
- v wraps modulo 2^14: 0x3FFF + 1 = 0x0000, and 0x3FE0 + 32 = 0x0000.
- States are IDLE, WRITE, REQ, CAP, PREQ, PCAP. `busy` = (state != IDLE).
- Strobes sampled while `busy` is high are dropped with no side effect, including on `w`.
- If `cpu_wr` and `cpu_rd` are asserted in the same cycle, the write is taken and the read is dropped.
- Writes to v via $2006 only change `mem_addr` while in IDLE. `mem_addr` is stable throughout any memory access.

## Timing
- Reset value of every output is 0. Internal registers also reset to 0, and state resets to IDLE.
- Reset asserted mid-access aborts the access immediately: `mem_wr`/`mem_rd` drop without waiting for a clock edge, and v is not incremented.
- All outputs are registered; there are no combinational paths from CPU inputs to outputs.
- **Write latency:** `mem_wr` is high in the cycle after the sampling edge; `busy` is high for 1 cycle.
- **Non-palette read:** `cpu_data_out` is valid the cycle after the sampling edge. `busy` is high for 2 cycles (REQ, CAP).
- **Palette read:** `cpu_data_out` updates at the CAP edge. `busy` is high for 4 cycles with the fill enabled, 2 without.
- The next strobe is accepted the first cycle `busy` is low.

## Structure
- Package `ppu_pkg` holds:
  - the state enum;
  - register selects `REG_PPUCTRL`=0, `REG_PPUSTATUS`=2, `REG_PPUADDR`=6, `REG_PPUDATA`=7;
  - `PALETTE_BASE`=14'h3F00 and `NT_MIRROR_OFS`=14'h1000.
- Single flat module, no sub-module.
- `ppu_mem_decode` is instantiated by the parent, fed from `mem_addr`.

## Test plan
- **Address latch and write:** write $2006=0x21, $2006=0x08, $2007=0x55. Expect `mem_wr` for one cycle with `mem_addr`=0x2108, `mem_wdata`=0x55; next access is at 0x2109.
- **Delayed read:** model memory has 0x2000=0xAA and 0x2001=0xBB; after reset, set v=0x2000. Read $2007 three times. Expect `cpu_data_out` = 0x00, then 0xAA, then 0xBB.
- **Palette read:** 0x3F00=0x0F, 0x2F00=0x33, v=0x3F00. First read returns 0x0F; a read after setting v=0x2000 returns 0x33 from the buffer.
- **Increment mode and wrap:** $2000=0x04, v=0x3FE0, write $2007. Expect v=0x0000. With $2000=0x00 and v=0x3FFF, a write also gives v=0x0000.
- **Toggle reset:** $2006=0x3F, then $2002 read, then $2006=0x23, $2006=0x00. Expect v=0x2300.
- **Busy, collision and reset:** a $2006 write during `busy` is dropped. `cpu_wr` and `cpu_rd` together on $2007 produce a write only. `rst` asserted during REQ clears `mem_rd` asynchronously and leaves v at 0.
